// File: rtl/rotation_sequencer.sv
// rtl/rotation_sequencer.sv - multi-cycle either-direction word rotator with start/busy/done
// One single-bit rotation per clock until the latched amount is used up.
module rotation_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CW-1:0]    amount,
  input  logic             dir,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] REM_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [WIDTH-1:0] dout_nx;
  logic [CW-1:0]    rem, rem_nx;
  logic             dir_q, dir_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dout  <= '0;
      rem   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_nx;
      dout  <= dout_nx;
      rem   <= rem_nx;
      dir_q <= dir_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dout_nx  = dout;
    rem_nx   = rem;
    dir_nx   = dir_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          dout_nx  = din;
          rem_nx   = amount;
          dir_nx   = dir;
          state_nx = (amount == '0) ? S_FIN : S_ROT;
        end
      end
      S_ROT: begin
        busy = 1'b1;
        // left: MSB wraps to LSB; right: LSB wraps to MSB
        if (dir_q) begin
          dout_nx = {dout[WIDTH-2:0], dout[WIDTH-1]};
        end else begin
          dout_nx = {dout[0], dout[WIDTH-1:1]};
        end
        rem_nx = rem - REM_ONE;
        if (rem == REM_ONE) begin
          state_nx = S_FIN;
        end
      end
      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rotation_sequencer.sv
// tb/tb_rotation_sequencer.sv - randomized and directed checks of rotation_sequencer
// Reference model tracks each accepted request as (source word, amount, direction, cycles elapsed).
module tb_rotation_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic [2:0] amount;
  logic       dir;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // model state
  int         m_left = 0;
  int         m_step = 0;
  int         m_k    = 0;
  logic [7:0] m_src  = 8'h00;
  logic       m_dir  = 1'b0;
  logic [7:0] m_dout = 8'h00;

  logic [7:0] hist [0:15];

  rotation_sequencer #(.WIDTH(8), .CW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (din),
    .amount (amount),
    .dir    (dir),
    .busy   (busy),
    .done   (done),
    .dout   (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rot(input logic [7:0] x, input int n, input logic d);
    logic [15:0] w;
    logic [15:0] s;
    w = {x, x};
    if (d) begin
      s = w << n;
      return s[15:8];
    end else begin
      s = w >> n;
      return s[7:0];
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_step = 0;
      m_dout = 8'h00;
    end else if (m_left == 0 && start) begin
      m_src  = din;
      m_k    = int'(amount);
      m_dir  = dir;
      m_step = 0;
      m_left = m_k + 1;
      m_dout = din;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_step < m_k) m_step = m_step + 1;
      m_dout = rot(m_src, m_step, m_dir);
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {7'd0, busy}, {7'd0, m_left != 0});
      check("done", {7'd0, done}, {7'd0, m_left == 1});
      check("dout", dout, m_dout);
    end
  end

  // Called right after a negedge with the DUT idle; returns at the negedge showing done.
  task automatic run_op(input string name, input logic [7:0] d, input logic [2:0] a,
                        input logic dr, input logic [7:0] want, input int want_lat);
    int lat;
    start  = 1'b1;
    din    = d;
    amount = a;
    dir    = dr;
    @(negedge clk);
    start = 1'b0;
    din   = $urandom;
    lat   = 1;
    hist[1] = dout;
    while (!done && lat < 15) begin
      @(negedge clk);
      lat++;
      hist[lat] = dout;
    end
    check({name, "_lat"}, 8'(lat), 8'(want_lat));
    check({name, "_dout"}, dout, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    din    = 8'hFF;
    amount = 3'd2;
    dir    = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("reset_dout", dout, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);
    check("reset_done", {7'd0, done}, 8'h00);

    run_op("r1", 8'b10100001, 3'd1, 1'b0, 8'b11010000, 2);
    @(negedge clk);
    run_op("r7", 8'b10100001, 3'd7, 1'b0, 8'b01000011, 8);
    @(negedge clk);
    run_op("r3", 8'b00000001, 3'd3, 1'b0, 8'b00100000, 4);
    check("r3_mid1", hist[2], 8'b10000000);
    check("r3_mid2", hist[3], 8'b01000000);
    @(negedge clk);
    run_op("l1", 8'b01111111, 3'd1, 1'b1, 8'b11111110, 2);
    @(negedge clk);
    run_op("z0", 8'b10000001, 3'd0, 1'b0, 8'b10000001, 1);
    @(negedge clk);
    check("z0_idle_busy", {7'd0, busy}, 8'h00);

    // starts during ROT and FIN are dropped; the edge after FIN accepts
    start = 1'b1; din = 8'b10100001; amount = 3'd5; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; din = 8'hFF; amount = 3'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_done", {7'd0, done}, 8'h01);
    check("ign_dout", dout, 8'b00001101);
    start = 1'b1; din = 8'hFF; amount = 3'd0;
    @(negedge clk);
    check("ign_fin_busy", {7'd0, busy}, 8'h00);
    check("ign_fin_dout", dout, 8'b00001101);
    din = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done", {7'd0, done}, 8'h01);
    check("b2b_dout", dout, 8'h3C);
    @(negedge clk);

    // reset in the middle of a rotation
    start = 1'b1; din = 8'b11000101; amount = 3'd6; dir = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_busy", {7'd0, busy}, 8'h00);
    check("mid_rst_done", {7'd0, done}, 8'h00);
    run_op("post_rst", 8'b11000101, 3'd2, 1'b1, 8'b00010111, 3);
    @(negedge clk);

    for (int c = 0; c < 4000; c++) begin
      rst    = ($urandom_range(0, 249) == 0);
      start  = ($urandom_range(0, 2) == 0);
      din    = 8'($urandom);
      amount = 3'($urandom);
      dir    = 1'($urandom);
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rotation_sequencer.md
# rotation_sequencer

Multi-cycle rotation engine. Latches an 8-bit word, a rotate amount, and a direction on a one-cycle `start` strobe. Applies one single-bit rotation per clock until the amount is exhausted, then presents the result with a one-cycle `done` pulse. It consumes the same words as the single-bit right-rotation stage and extends it to N-bit, either-direction rotation under a start/busy/done handshake.

## Interface
- `WIDTH`, 8, data word width.
- `CW`, 3, rotate-amount width. `WIDTH` must equal 2**`CW`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe. Sampled only in IDLE.
- `din`  in  WIDTH  word to rotate. Latched with `start`.
- `amount`  in  CW  number of 1-bit rotations, 0..7. Latched with `start`.
- `dir`  in  1  direction: 0 = right (LSB wraps to MSB), 1 = left (MSB wraps to LSB). Latched with `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse; result valid on `dout`.
- `dout`  out  WIDTH  working register. Holds the final result from `done` until the next accepted `start` or reset.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - ROT: `busy`=1, `done`=0.
  - FIN: `busy`=1, `done`=1.
- IDLE, `start`=1 at an edge:
  - Load `dout`<=`din`, `rem`<=`amount`, latch `dir`.
  - If `amount`=0, go to FIN; otherwise go to ROT.
- IDLE, `start`=0: hold all registers.
- ROT, at each edge:
  - Right: `dout`<={`dout`[0], `dout`[WIDTH-1:1]}.
  - Left: `dout`<={`dout`[WIDTH-2:0], `dout`[WIDTH-1]}.
  - `rem`<=`rem`-1.
  - When `rem`=1 before the edge, this is the last rotation; next state is FIN.
- FIN: unconditionally return to IDLE at the next edge. `dout` is unchanged.
- `start` in ROT or FIN is ignored. No queuing: the request is lost, and `din`, `amount`, `dir` are not sampled.
- `din`, `amount`, `dir` changing during ROT/FIN has no effect.
- `rem` is CW bits and never underflows. ROT is entered only with `rem`>=1.
- Rotation is circular. No bits are lost, and popcount(`dout`) = popcount(`din`) at FIN.

## Timing
- Reset values (any state, including mid-ROT): state IDLE, `dout`=0, `rem`=0, `busy`=0, `done`=0. Reset has priority over `start`.
- Let E0 be the edge where `start` is accepted, with amount k:
  - `busy` rises after E0.
  - Rotations occur at edges E1..Ek.
  - `done`=1 during the cycle after E(k) (after E0 when k=0).
  - `done` falls and `busy` falls after the following edge.
- Latency from start edge to `done` is k+1 cycles; total busy time is k+1 cycles. Max latency is 8 cycles (k=7).
- Back-to-back: a new `start` is accepted at the first edge with state IDLE, i.e. the edge after FIN. Minimum request spacing is k+2 cycles.
- `dout` is registered, with no combinational path from inputs to outputs.
- During ROT, `dout` shows intermediate values. Consumers sample only on `done`=1.

## Test plan
- Reset asserted 2 cycles, then released -> `dout`=00000000, `busy`=0, `done`=0. A `start` during reset is ignored.
- `din`=10100001, `amount`=1, `dir`=0 -> `done` 2 cycles after start edge, `dout`=11010000. Then `din`=10100001, `amount`=7, `dir`=0 -> `done` after 8 cycles, `dout`=01000011.
- `din`=00000001, `amount`=3, `dir`=0 -> intermediate `dout` 10000000, 01000000, then `dout`=00100000 with `done`. Then `din`=01111111, `amount`=1, `dir`=1 -> `dout`=11111110.
- `din`=10000001, `amount`=0 -> `busy` 1 cycle, `done` 1 cycle after start, `dout`=10000001.
- Start `din`=10100001, `amount`=5; pulse `start` with `din`=11111111 during ROT and during FIN -> both ignored. Result is right-rotate-5 = 00001101. Next `start` is accepted on the edge after FIN.
- Assert `rst` 2 cycles into an amount=6 rotation -> next cycle `dout`=0, `busy`=0, no `done` pulse. A fresh `start` after release completes normally.
